sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 42 ++++
 rtl/sync_fifo.sv | 100 ++++++++++
 tb/tb_sync_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the byte FIFO: default geometry and derived widths.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Derived widths for the default geometry.
  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointer width for an arbitrary power-of-two depth (minimum 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one write port and a registered read port.
// Storage is not reset. The read data register is reset to zero so that the
// FIFO output shows zero until the first accepted read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Write port: store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word on an accepted read, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty status and
// one-cycle overflow/underflow pulses. Rejected accesses leave state intact.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic wr_acc;
  logic rd_acc;

  // Status comes straight from the registered count, so it is valid right
  // after the edge that changed it and has no path from the inputs.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // A read frees a slot in the same edge, so a write while full is still
  // accepted when paired with a read.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  // Pointer advance on accepted accesses; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Occupancy tracking: simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Error pulses: flag the access rejected at the previous edge, self-clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_en && full && !rd_en;
      underflow_reg <= rd_en && empty;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_reg),
    .wdata (in),
    .re    (rd_acc),
    .raddr (rd_ptr_reg),
    .rdata (out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed steps from the test plan plus a
// randomized phase, all compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] out_m;
  logic             ovf_m;
  logic             udf_m;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .in        (in),
    .out       (out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},       32'(out),       32'(out_m));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(ovf_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(udf_m));
  endtask

  // One clock transaction: drive, predict, clock, compare.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
    int sz;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    in    = d;
    sz    = q.size();
    ovf_m = w && (sz == DEPTH) && !r;
    udf_m = r && (sz == 0);
    if (r && sz > 0) out_m = q.pop_front();
    if (w && (sz < DEPTH || r)) q.push_back(d);
    @(posedge clk);
    #1;
    $display("%s wr=%0b rd=%0b in=%02h -> out=%02h full=%0b empty=%0b ovf=%0b udf=%0b",
             tag, w, r, d, out, full, empty, overflow, underflow);
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    out_m = '0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endtask

  initial begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    in    = 8'd15;
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Read from empty after reset
    cycle("rd_empty", 1'b0, 1'b1, 8'd15);
    check("rd_empty.udf_const", 32'(underflow), 32'd1);
    cycle("idle0", 1'b0, 1'b0, 8'd15);
    check("idle0.udf_cleared", 32'(underflow), 32'd0);

    // Fill, then overflow
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 1'b0, 8'(16 + i));
    check("fill.full_const", 32'(full), 32'd1);
    cycle("ovf", 1'b1, 1'b0, 8'd20);
    check("ovf.const", 32'(overflow), 32'd1);
    cycle("idle1", 1'b0, 1'b0, 8'd0);

    // Drain, then underflow
    for (int i = 0; i < 4; i++) begin
      cycle("drain", 1'b0, 1'b1, 8'd0);
      check("drain.out_const", 32'(out), 32'(16 + i));
    end
    cycle("udf", 1'b0, 1'b1, 8'd0);
    check("udf.out_hold", 32'(out), 32'd19);

    // Wrap-around
    for (int i = 0; i < 3; i++) cycle("wrap_w3", 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) cycle("wrap_r3", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) cycle("wrap_w4", 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) cycle("wrap_r4", 1'b0, 1'b1, 8'd0);
    check("wrap.last_const", 32'(out), 32'hA3);

    // Simultaneous read+write when full and when empty
    for (int i = 0; i < 4; i++) cycle("sim_fill", 1'b1, 1'b0, 8'(8'h30 + i));
    cycle("sim_full", 1'b1, 1'b1, 8'h34);
    check("sim_full.out_const", 32'(out), 32'h30);
    for (int i = 0; i < 4; i++) cycle("sim_drain", 1'b0, 1'b1, 8'd0);
    cycle("sim_empty", 1'b1, 1'b1, 8'h55);
    check("sim_empty.udf_const", 32'(underflow), 32'd1);
    check("sim_empty.empty_const", 32'(empty), 32'd0);
    cycle("sim_empty_rd", 1'b0, 1'b1, 8'd0);
    check("sim_empty_rd.out_const", 32'(out), 32'h55);

    // Asynchronous reset mid-cycle with two entries queued
    cycle("pre_rst", 1'b1, 1'b0, 8'h61);
    cycle("pre_rst", 1'b1, 1'b0, 8'h62);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    $display("async_reset -> out=%02h full=%0b empty=%0b ovf=%0b udf=%0b",
             out, full, empty, overflow, underflow);
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst_rd", 1'b0, 1'b1, 8'd0);
    check("post_rst_rd.udf_const", 32'(underflow), 32'd1);
    cycle("post_rst_w", 1'b1, 1'b0, 8'h77);
    cycle("post_rst_r", 1'b0, 1'b1, 8'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
